// File: rtl/code_sequencer.sv
// code_sequencer: scans the 5-bit code space and emits every detect-true code over valid/ready.
// Optional CODE_SEQ_PARITY_EN adds a registered odd-parity output code_par.
module code_sequencer #(
    parameter bit DIR_DOWN = 1'b0,
    parameter int MAX_CODE = 31
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       out_ready,
    output logic [4:0] code,
    output logic       code_valid,
    output logic       busy,
    output logic       done,
`ifdef CODE_SEQ_PARITY_EN
    output logic       code_par,
`endif
    output logic [3:0] match_count
);
    typedef enum logic [1:0] {IDLE, SCAN, HOLD, DONE} state_t;
    localparam logic [4:0] MAX   = 5'(MAX_CODE);
    localparam logic [4:0] FIRST = DIR_DOWN ? MAX : 5'd0;
    localparam logic [4:0] LAST  = DIR_DOWN ? 5'd0 : MAX;
    state_t     state, state_nxt;
    logic [4:0] idx, idx_nxt, code_nxt, idx_step;
    logic [3:0] cnt_nxt;
    logic       is_last;
    function automatic logic detect(input logic [4:0] x);
        return (~x[0] & ~x[1]) | (x[4] & x[3] & x[2] & ~x[0]) |
               (x[4] & ~x[3] & ~x[2] & ~x[0]) | (~x[4] & ~x[3] & x[2] & ~x[0]);
    endfunction
    assign is_last  = idx == LAST;
    assign idx_step = DIR_DOWN ? idx - 5'd1 : idx + 5'd1;
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        code_nxt  = code;
        cnt_nxt   = match_count;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    idx_nxt   = FIRST;
                    cnt_nxt   = 4'd0;
                    state_nxt = SCAN;
                end
                SCAN: if (detect(idx)) begin
                    code_nxt  = idx;
                    state_nxt = HOLD;
                end else begin
                    state_nxt = is_last ? DONE : SCAN;
                    idx_nxt   = is_last ? idx : idx_step;
                end
                HOLD: if (code_valid && out_ready) begin
                    cnt_nxt   = match_count + 4'd1;
                    state_nxt = is_last ? DONE : SCAN;
                    idx_nxt   = is_last ? idx : idx_step;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end
    // every output is a register loaded from the next-state decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= 5'd0;
            code        <= 5'd0;
            code_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            match_count <= 4'd0;
`ifdef CODE_SEQ_PARITY_EN
            code_par    <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            code        <= code_nxt;
            code_valid  <= state_nxt == HOLD;
            busy        <= (state_nxt == SCAN) || (state_nxt == HOLD);
            done        <= state_nxt == DONE;
            match_count <= cnt_nxt;
`ifdef CODE_SEQ_PARITY_EN
            code_par    <= ^code_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_code_sequencer.sv
// tb_code_sequencer: scoreboard bench for an ascending (0..31) and a descending (20..0) sequencer.
module tb_code_sequencer;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, ready = 1'b0, sel = 1'b0;
    logic [4:0] code_a, code_b, obs_code;
    logic       valid_a, valid_b, busy_a, busy_b, done_a, done_b, par_a, par_b;
    logic       obs_valid, obs_busy, obs_done, obs_par;
    logic [3:0] cnt_a, cnt_b, obs_cnt;
    int         checks = 0, errors = 0;
    int         q[$];
    logic [31:0] true_set = 32'h5115_1151;
    always #5 clk = ~clk;
`ifndef CODE_SEQ_PARITY_EN
    assign par_a = 1'b0;
    assign par_b = 1'b0;
`endif
    code_sequencer #(.DIR_DOWN(1'b0), .MAX_CODE(31)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel), .abort(abort & ~sel), .out_ready(ready & ~sel),
        .code(code_a), .code_valid(valid_a), .busy(busy_a), .done(done_a),
`ifdef CODE_SEQ_PARITY_EN
        .code_par(par_a),
`endif
        .match_count(cnt_a));
    code_sequencer #(.DIR_DOWN(1'b1), .MAX_CODE(20)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .abort(abort & sel), .out_ready(ready & sel),
        .code(code_b), .code_valid(valid_b), .busy(busy_b), .done(done_b),
`ifdef CODE_SEQ_PARITY_EN
        .code_par(par_b),
`endif
        .match_count(cnt_b));
    assign obs_code  = sel ? code_b  : code_a;
    assign obs_valid = sel ? valid_b : valid_a;
    assign obs_busy  = sel ? busy_b  : busy_a;
    assign obs_done  = sel ? done_b  : done_a;
    assign obs_par   = sel ? par_b   : par_a;
    assign obs_cnt   = sel ? cnt_b   : cnt_a;
    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic run(input int stall_code, input int abort_code, input int exp_cnt);
        int stalls = 0, guard = 0, last = -1;
        bit fin = 0;
        q.delete();
        for (int k = 0; k < 32; k++) begin
            int v = sel ? 20 - k : k;
            if (v >= 0 && true_set[v]) q.push_back(v);
        end
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("busy_after_start", obs_busy, 1);
        while (!fin && guard < 300) begin
            ready = 1'b1;
            if (obs_valid && obs_code == abort_code) begin
                ready = 1'b0;
                abort = 1'b1;
                @(negedge clk) abort = 1'b0;
                check("abort_valid", obs_valid, 0);
                check("abort_busy", obs_busy, 0);
                check("abort_done", obs_done, 0);
                check("abort_count", obs_cnt, exp_cnt);
                @(negedge clk);
                check("abort_no_done", obs_done, 0);
                return;
            end
            if (stalls > 0 && stalls < 5) begin
                ready = 1'b0;
                check("bp_valid", obs_valid, 1);
                check("bp_code", obs_code, stall_code);
                stalls++;
            end else if (stalls == 0 && obs_valid && obs_code == stall_code) begin
                ready = 1'b0;
                stalls = 1;
            end
            if (ready && obs_valid) begin
                if (q.size() == 0) check("sb_extra_code", obs_code, -1);
                else begin
                    last = q.pop_front();
                    check("code", obs_code, last);
`ifdef CODE_SEQ_PARITY_EN
                    check("code_par", obs_par, $countones(last) & 1);
`endif
                end
            end
            if (obs_done) begin
                check("done_count", obs_cnt, exp_cnt);
                check("sb_missing", q.size(), 0);
                fin = 1;
            end
            @(negedge clk);
            guard++;
        end
        if (!fin) check("scan_timeout", guard, 0);
        check("done_one_cycle", obs_done, 0);
        check("busy_after_done", obs_busy, 0);
        check("code_retained", obs_code, last);
    endtask
    initial begin
        repeat (3) @(negedge clk);
        check("rst_code", code_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_cnt", cnt_b, 0);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("idle_quiet", {valid_a, busy_a, done_a, valid_b, busy_b, done_b}, 0);
        end
        check("idle_code", code_a | code_b, 0);
        check("idle_par", par_a | par_b, 0);
        run(6, -1, 11);
        run(-1, 12, 4);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        check("abort_beats_start", busy_a, 0);
        check("abort_start_cnt", cnt_a, 4);
        run(-1, -1, 11);
        sel = 1'b1;
        run(-1, -1, 8);
        sel = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 10 && !valid_a; i++) @(negedge clk);
        check("pre_reset_valid", valid_a, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", valid_a, 0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_code", code_a, 0);
        check("mid_rst_cnt", cnt_a, 0);
        check("mid_rst_done", done_a, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", busy_a, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/code_sequencer.md
Name: code_sequencer

Overview:
- Source side of the 5-bit code-detect function used in the logic-design lab.
- Sequentially scans the 5-bit code space and emits, one at a time over a valid/ready handshake, every value for which the detect function is true.
- Counts emitted codes and pulses done at the end of the scan.
- Feeds the detector under test, or any consumer that needs the legal code set in order.

Parameters:
- DIR_DOWN, 0, scan direction: 0 ascends from 0 to MAX_CODE; 1 descends from MAX_CODE to 0.
- MAX_CODE, 31, upper scan bound; legal range 0..31.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a scan; sampled only in IDLE.
- abort  input  1  synchronous abort; sampled in every state.
- out_ready  input  1  consumer accepts code this cycle.
- code  output  5  current emitted code.
- code_valid  output  1  code is valid.
- busy  output  1  high in SCAN or HOLD.
- done  output  1  one-cycle pulse at scan completion.
- match_count  output  4  number of codes accepted in the current or last scan.

Behaviour:
- Detect function f(x), x[4:0]:
  - f(x) = ~x0&~x1 | x4&x3&x2&~x0 | x4&~x3&~x2&~x0 | ~x4&~x3&x2&~x0.
  - Full-range true set: {0,4,6,8,12,16,18,20,24,28,30}, 11 values.
- Reset (rst_n low, asynchronous):
  - state=IDLE, idx=0, code=0.
  - code_valid=0, busy=0, done=0, match_count=0.
- State machine: IDLE, SCAN, HOLD, DONE. All outputs are registered.
- IDLE:
  - On start=1: idx <= (DIR_DOWN ? MAX_CODE : 0), match_count <= 0, go to SCAN.
  - Otherwise stay.
- SCAN (one candidate per cycle):
  - If f(idx): code <= idx, code_valid <= 1, go to HOLD.
  - Else if idx is the last value (MAX_CODE ascending, 0 descending): go to DONE.
  - Else: step idx by +1 or -1.
- HOLD:
  - code and code_valid are held stable while out_ready=0.
  - On code_valid&out_ready:
    - code_valid <= 0, match_count++.
    - If idx is the last value, go to DONE.
    - Else step idx and return to SCAN.
- DONE: done=1 for exactly one cycle, then go to IDLE. code retains the last emitted value.
- Latency:
  - start sampled at edge N puts the first candidate in SCAN at N+1.
  - The first matching code is valid after edge N+2.
  - Each match costs 2 cycles with out_ready=1; each non-match costs 1 cycle.
- idx never wraps: the scan terminates at its bound. start is ignored outside IDLE.
- abort=1 in any state: next edge forces IDLE and clears code_valid and done. match_count is kept. abort has priority over start and the handshake.
- abort and start together in IDLE: abort wins, stay IDLE.
- Reset mid-scan returns everything to reset values immediately. Any handshake in flight is lost.
- match_count does not overflow: at most 11 codes exist in 0..31.

Optional Feature:
- Macro CODE_SEQ_PARITY_EN.
  - Defined: adds output code_par (1 bit), registered alongside code and equal to ^code (odd-ones indicator). Reset value 0; held with code in HOLD.
  - Undefined: port and logic absent. Behaviour otherwise identical.

Test Plan:
- Reset and idle:
  - Stimulus: rst_n low for 3 cycles, then high, start=0 for 10 cycles.
  - Response: all outputs 0, state IDLE, no code_valid.
- Full ascending scan:
  - Stimulus: DIR_DOWN=0, MAX_CODE=31, out_ready=1, start pulse.
  - Response: codes 0,4,6,8,12,16,18,20,24,28,30 in order; match_count=11; one done pulse after idx 31 is scanned; busy low afterwards.
- Descending scan with reduced bound:
  - Stimulus: DIR_DOWN=1, MAX_CODE=20.
  - Response: codes 20,18,16,12,8,6,4,0; match_count=8; done after code 0 is accepted.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles while code=6 is valid.
  - Response: code=6 and code_valid stable throughout; accepted on the first out_ready=1 cycle; next code 8; no value duplicated or skipped.
- Abort and mid-scan reset:
  - Stimulus: abort while code=12 is pending.
  - Response: next cycle IDLE, code_valid=0, no done; match_count=4 retained; a following start rescans from 0.
  - Stimulus: rst_n low during HOLD.
  - Response: outputs at reset values immediately.
- Parity (CODE_SEQ_PARITY_EN):
  - Stimulus: full ascending scan.
  - Response: code_par sequence 0,1,0,1,0,1,0,0,0,1,0 aligned with codes.
